// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arithmetic slice: default operand width and
// divider FSM state encoding.
package alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/divider_add_eq_if.sv
// Operand/result bundle between the operand registers and the arithmetic slice.
interface divider_add_eq_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             start;
    logic [WIDTH-1:0] add_out;
    logic             final_carry;
    logic             eq_out;
    logic [WIDTH-1:0] div_out;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output in1, in2, start,
        input  add_out, final_carry, eq_out, div_out, remainder, div_by_zero, busy, done
    );

    modport slave (
        input  in1, in2, start,
        output add_out, final_carry, eq_out, div_out, remainder, div_by_zero, busy, done
    );

endinterface

// File: rtl/restoring_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle MSB first, with a
// start/busy/done handshake. Results hold until the next division completes.
module restoring_div_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             start,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] res_rem_q, res_rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             trial_ge;

    // A zero divisor needs no special case: every trial "fits", so the quotient
    // fills with ones and the remainder ends up as the shifted-in dividend.
    always_comb begin
        trial     = {rem_q, dvd_q[WIDTH-1]};
        trial_ge  = (trial >= {1'b0, dvs_q});
        diff      = trial[WIDTH-1:0] - dvs_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        res_rem_d = res_rem_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    cnt_d   = CntW'(WIDTH);
                    state_d = RUN;
                end
            end
            RUN: begin
                // Dividend bits shift out the top while quotient bits shift in below.
                dvd_d = {dvd_q[WIDTH-2:0], trial_ge};
                rem_d = trial_ge ? diff : trial[WIDTH-1:0];
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    quo_d     = dvd_d;
                    res_rem_d = rem_d;
                    dbz_d     = (dvs_q == '0);
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            res_rem_q <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            res_rem_q <= res_rem_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = res_rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q == RUN);
    assign done        = done_q;

endmodule

// File: rtl/divider_add_eq.sv
// Registered arithmetic slice: carry-out adder and equality compare (1-cycle)
// alongside a multi-cycle restoring divider.
module divider_add_eq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input logic             clk,
    input logic             rst_n,
    divider_add_eq_if.slave bus
);

    logic [WIDTH-1:0] add_q, add_d;
    logic             carry_q, carry_d;
    logic             eq_q, eq_d;

    always_comb begin
        {carry_d, add_d} = {1'b0, bus.in1} + {1'b0, bus.in2};
        eq_d             = (bus.in1 == bus.in2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_q   <= '0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            add_q   <= add_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
        end
    end

    restoring_div_core #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .dividend    (bus.in1),
        .divisor     (bus.in2),
        .start       (bus.start),
        .quotient    (bus.div_out),
        .remainder   (bus.remainder),
        .div_by_zero (bus.div_by_zero),
        .busy        (bus.busy),
        .done        (bus.done)
    );

    assign bus.add_out     = add_q;
    assign bus.final_carry = carry_q;
    assign bus.eq_out      = eq_q;

endmodule

// File: tb/tb_divider_add_eq.sv
// Self-checking bench for divider_add_eq: adder/eq sweeps and divider scenarios
// compared against plain-arithmetic reference results.
module tb_divider_add_eq;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;
    int   done_cnt;

    divider_add_eq_if #(.WIDTH(W)) bus ();

    divider_add_eq #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom_range((1 << W) - 1, 0));
    endfunction

    // Reference divider: plain integer arithmetic with the zero-divisor rule.
    function automatic logic [W-1:0] ref_q(input int a, input int b);
        return (b == 0) ? {W{1'b1}} : W'(a / b);
    endfunction

    function automatic logic [W-1:0] ref_r(input int a, input int b);
        return (b == 0) ? W'(a) : W'(a % b);
    endfunction

    task automatic check_all_zero(input string name);
        logic [3*W+5:0] obs;
        obs = {bus.add_out, bus.final_carry, bus.eq_out, bus.div_out, bus.remainder,
               bus.div_by_zero, bus.busy, bus.done};
        vectors++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL %s: outputs=%h required all zero", name, obs);
        end
    endtask

    task automatic test_reset();
        bus.in1   = 4'd9;
        bus.in2   = 4'd9;
        bus.start = 1'b1;
        rst_n     = 1'b0;
        #12;
        check_all_zero("reset_state");
        tick();
        check_all_zero("reset_held_across_edge");
        bus.start = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_adder();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                bus.in1 = W'(a);
                bus.in2 = W'(b);
                tick();
                vectors++;
                if ({bus.final_carry, bus.add_out} !== 5'(a + b)) begin
                    errors++;
                    $display("FAIL adder %0d+%0d: got %0d carry %0d required sum %0d",
                             a, b, bus.add_out, bus.final_carry, a + b);
                end
            end
        end
    endtask

    task automatic test_eq();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        ta = '{4'd5, 4'd5, 4'd0, 4'd15};
        tb = '{4'd5, 4'd6, 4'd0, 4'd14};
        for (int i = 0; i < 24; i++) begin
            if (i < 4) begin
                bus.in1 = ta[i];
                bus.in2 = tb[i];
            end else begin
                bus.in1 = rnd();
                bus.in2 = (i % 3 == 0) ? bus.in1 : rnd();
            end
            tick();
            vectors++;
            if (bus.eq_out !== (bus.in1 == bus.in2)) begin
                errors++;
                $display("FAIL eq %0d==%0d: got %0b required %0b",
                         bus.in1, bus.in2, bus.eq_out, bus.in1 == bus.in2);
            end
        end
    endtask

    // Issues a start, checks busy/done every cycle, and returns in the done cycle.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in1   = a;
        bus.in2   = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= W; k++) begin
            vectors++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL div_busy %0d/%0d cyc %0d: busy=%0b done=%0b required 1 0",
                         a, b, k, bus.busy, bus.done);
            end
            bus.in1 = rnd();
            bus.in2 = rnd();
            tick();
        end
        vectors++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.div_out !== ref_q(a, b) ||
            bus.remainder !== ref_r(a, b) || bus.div_by_zero !== (b == 0)) begin
            errors++;
            $display("FAIL div_result %0d/%0d: q=%0d r=%0d dbz=%0b done=%0b busy=%0b required q=%0d r=%0d dbz=%0b done=1 busy=0",
                     a, b, bus.div_out, bus.remainder, bus.div_by_zero, bus.done, bus.busy,
                     ref_q(a, b), ref_r(a, b), b == 0);
        end
    endtask

    task automatic test_divide();
        logic [W-1:0] qa;
        logic [W-1:0] qr;
        run_div(4'd13, 4'd4);
        tick();
        qa = ref_q(13, 4);
        qr = ref_r(13, 4);
        vectors++;
        if (bus.done !== 1'b0 || bus.div_out !== qa || bus.remainder !== qr) begin
            errors++;
            $display("FAIL div_hold: done=%0b q=%0d r=%0d required done=0 q=%0d r=%0d",
                     bus.done, bus.div_out, bus.remainder, qa, qr);
        end
        run_div(4'd15, 4'd1);
        run_div(4'd3, 4'd7);
        run_div(4'd9, 4'd0);
        for (int i = 0; i < 20; i++) begin
            run_div(rnd(), (i % 5 == 0) ? 4'd0 : rnd());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        done_cnt  = 0;
        bus.in1   = 4'd12;
        bus.in2   = 4'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.in1   = 4'd6;
        bus.in2   = 4'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 3; k <= W; k++) begin
            if (bus.done === 1'b1) done_cnt++;
            tick();
        end
        if (bus.done === 1'b1) done_cnt++;
        vectors++;
        if (done_cnt != 1 || bus.div_out !== 4'd2 || bus.remainder !== 4'd2) begin
            errors++;
            $display("FAIL start_while_busy: dones=%0d q=%0d r=%0d required dones=1 q=2 r=2",
                     done_cnt, bus.div_out, bus.remainder);
        end
        run_div(4'd6, 4'd2);
        tick();
    endtask

    task automatic test_async_reset();
        bus.in1   = 4'd14;
        bus.in2   = 4'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset_mid_run");
        #3;
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < W + 2; k++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
        end
        vectors++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL aborted_div_activity: cycles with busy/done=%0d required 0", done_cnt);
        end
        run_div(4'd14, 4'd3);
        tick();
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        bus.start = 1'b0;
        test_reset();
        test_adder();
        test_eq();
        test_divide();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
